// File: rtl/beamformer_pkg.sv
// Shared types and default sizes for the beamformer output path.
package beamformer_pkg;

    localparam int NUMBER_OF_BITS = 16;
    localparam int SLOT_BITS      = 32;

    typedef logic signed [NUMBER_OF_BITS-1:0] pcm_sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pcm_to_i2s_if.sv
// Left/right PCM sample-pair stream with a valid/ready handshake.
interface pcm_to_i2s_if #(
    parameter int NUMBER_OF_BITS = 16
) ();

    logic                      s_valid;
    logic                      s_ready;
    logic [NUMBER_OF_BITS-1:0] s_left;
    logic [NUMBER_OF_BITS-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/pcm_shift_out.sv
// Parallel-load, MSB-first shift register; zeros enter from the LSB end.
module pcm_shift_out #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/pcm_to_i2s.sv
// I2S transmitter: one-deep sample-pair holding register feeding left/right
// shift registers, with frame counter, word-select lead and underrun flag.
module pcm_to_i2s #(
    parameter int NUMBER_OF_BITS = beamformer_pkg::NUMBER_OF_BITS,
    parameter int SLOT_BITS      = beamformer_pkg::SLOT_BITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    pcm_to_i2s_if.slave  s,
    output logic         ws,
    output logic         sd,
    output logic         frame_sync,
    output logic         underrun
);

    import beamformer_pkg::state_t;
    import beamformer_pkg::IDLE;
    import beamformer_pkg::RUN;

    localparam int CW = (2 * SLOT_BITS > 1) ? $clog2(2 * SLOT_BITS) : 1;
    localparam logic [CW-1:0] LAST     = CW'(2 * SLOT_BITS - 1);
    localparam logic [CW-1:0] WS_RISE  = CW'(SLOT_BITS - 1);

    state_t                    state, state_nx;
    logic [CW-1:0]             cnt, cnt_nx;
    logic                      hold_full;
    logic [NUMBER_OF_BITS-1:0] hold_left, hold_right;

    logic                      boundary, start;
    logic                      shift_l, shift_r;
    logic                      l_msb, r_msb;
    logic                      ws_nx, sd_nx;
    logic [NUMBER_OF_BITS-1:0] load_l, load_r;

    // The left word is loaded one bit ahead because its MSB goes straight
    // from the holding register into sd at the frame boundary; the right
    // shifter starts moving one cycle before its slot for the same reason.
    assign load_l = hold_full ? (hold_left << 1) : '0;
    assign load_r = hold_full ? hold_right : '0;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shift_l  = 1'b0;
        shift_r  = 1'b0;
        boundary = (state == IDLE) ? en : (cnt == LAST);
        start    = boundary && en;

        if (start) begin
            state_nx = RUN;
            cnt_nx   = '0;
        end else if (boundary) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == RUN) begin
            cnt_nx  = cnt + 1'b1;
            shift_l = 1'b1;
            shift_r = (cnt >= WS_RISE);
        end

        ws_nx = (state_nx == RUN) && (cnt_nx >= WS_RISE) && (cnt_nx < LAST);

        if (start) begin
            sd_nx = hold_full && hold_left[NUMBER_OF_BITS-1];
        end else if (state == RUN && !boundary) begin
            sd_nx = (cnt < WS_RISE) ? l_msb : r_msb;
        end else begin
            sd_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A load needs hold_full and an accept needs it clear, so they never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full  <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
        end else if (start && hold_full) begin
            hold_full <= 1'b0;
        end else if (s.s_valid && !hold_full) begin
            hold_full  <= 1'b1;
            hold_left  <= s.s_left;
            hold_right <= s.s_right;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws         <= 1'b0;
            sd         <= 1'b0;
            frame_sync <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            ws         <= ws_nx;
            sd         <= sd_nx;
            frame_sync <= start;
            underrun   <= start && !hold_full;
        end
    end

    assign s.s_ready = !hold_full;

    pcm_shift_out #(.WIDTH(NUMBER_OF_BITS)) u_left (
        .clk   (clk),
        .reset (reset),
        .load  (start),
        .shift (shift_l),
        .data  (load_l),
        .msb   (l_msb)
    );

    pcm_shift_out #(.WIDTH(NUMBER_OF_BITS)) u_right (
        .clk   (clk),
        .reset (reset),
        .load  (start),
        .shift (shift_r),
        .data  (load_r),
        .msb   (r_msb)
    );

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Bench for pcm_to_i2s: frame-level reference model feeds a per-cycle
// expectation queue that a negedge monitor pops and compares.
module tb_pcm_to_i2s;

    localparam int NB = 16;
    localparam int SB = 32;
    localparam int FR = 2 * SB;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic ws, sd, frame_sync, underrun;

    pcm_to_i2s_if #(.NUMBER_OF_BITS(NB)) bus ();

    pcm_to_i2s #(.NUMBER_OF_BITS(NB), .SLOT_BITS(SB)) dut (
        .clk        (clk),
        .reset      (rst),
        .en         (en),
        .s          (bus.slave),
        .ws         (ws),
        .sd         (sd),
        .frame_sync (frame_sync),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // expectation word: {ws, sd, frame_sync, underrun, s_ready}
    logic [4:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference state: frame position, held pair, pair being transmitted
    bit            m_run, m_full;
    int            m_cnt;
    logic [NB-1:0] m_hl, m_hr, m_fl, m_fr;
    bit            m_acc, m_bnd, m_fs, m_ur;

    function automatic logic bit_at(int c, logic [NB-1:0] l, logic [NB-1:0] r);
        int            b;
        logic [NB-1:0] w;
        b = (c < SB) ? c : c - SB;
        w = (c < SB) ? l : r;
        return (b < NB) ? w[NB-1-b] : 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  = 1'b0;
            m_cnt  = 0;
            m_full = 1'b0;
            exp_q.delete();
            exp_q.push_back(5'b00001);
        end else begin
            m_acc = bus.s_valid && !m_full;
            m_bnd = m_run ? (m_cnt == FR - 1) : en;
            m_fs  = 1'b0;
            m_ur  = 1'b0;
            if (m_bnd && !en) begin
                m_run = 1'b0;
                m_cnt = 0;
            end else if (m_bnd) begin
                m_run  = 1'b1;
                m_cnt  = 0;
                m_fs   = 1'b1;
                m_ur   = !m_full;
                m_fl   = m_full ? m_hl : '0;
                m_fr   = m_full ? m_hr : '0;
                m_full = 1'b0;
            end else if (m_run) begin
                m_cnt++;
            end
            if (m_acc) begin
                m_full = 1'b1;
                m_hl   = bus.s_left;
                m_hr   = bus.s_right;
            end
            exp_q.push_back({m_run && m_cnt >= SB - 1 && m_cnt <= FR - 2,
                             m_run ? bit_at(m_cnt, m_fl, m_fr) : 1'b0,
                             m_fs, m_ur, !m_full});
        end
    end

    logic [4:0] mon_e, mon_a;
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {ws, sd, frame_sync, underrun, bus.s_ready};
            total++;
            if (mon_a !== mon_e) begin
                bad++;
                $display("FAIL outputs cyc=%0d ws/sd/fs/ur/rdy got=%b want=%b", cyc, mon_a, mon_e);
            end
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        cyc_n(2);
        rst = 1'b0;
    endtask

    task automatic push(input logic [NB-1:0] l, input logic [NB-1:0] r);
        bit ok;
        ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_left  = l;
        bus.s_right = r;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = bus.s_ready;
            cyc_n(1);
        end
        bus.s_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL push_timeout ready got=0 want=1");
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_left  = '0;
        bus.s_right = '0;
        cyc_n(3);
        rst = 1'b0;
        cyc_n(2);

        // basic frame, followed by an underrun frame
        push(16'hA5C3, 16'h1234);
        en = 1'b1;
        cyc_n(FR + 4);

        // underrun, then a pair pushed mid-frame
        do_reset();
        cyc_n(20);
        push(16'(($urandom)), 16'(($urandom)));
        cyc_n(2 * FR);

        // back-pressure: changing pair offered every cycle
        bus.s_valid = 1'b1;
        for (int i = 0; i < 3 * FR; i++) begin
            bus.s_left  = 16'($urandom);
            bus.s_right = 16'($urandom);
            cyc_n(1);
        end
        bus.s_valid = 1'b0;

        // same-edge accept on the IDLE->RUN boundary with hold empty
        en = 1'b0;
        do_reset();
        bus.s_valid = 1'b1;
        bus.s_left  = 16'h8001;
        bus.s_right = 16'h7FFE;
        en = 1'b1;
        cyc_n(1);
        bus.s_valid = 1'b0;
        cyc_n(2 * FR + 2);

        // disable near cnt 10 with a pair held; it must survive IDLE
        en = 1'b0;
        do_reset();
        push(16'hFFFF, 16'h0001);
        en = 1'b1;
        push(16'h5A5A, 16'hC3C3);
        cyc_n(9);
        en = 1'b0;
        cyc_n(2 * FR);
        en = 1'b1;
        cyc_n(FR + 4);

        // async reset around cnt 40 with a pair held
        en = 1'b0;
        do_reset();
        push(16'h1357, 16'h2468);
        en = 1'b1;
        push(16'hDEAD, 16'hBEEF);
        cyc_n(39);
        #2 rst = 1'b1;
        cyc_n(2);
        rst = 1'b0;
        cyc_n(FR + 4);

        // random traffic, enable toggles and occasional resets
        for (int i = 0; i < 1500; i++) begin
            bus.s_valid = ($urandom_range(0, 3) != 0);
            bus.s_left  = 16'($urandom);
            bus.s_right = 16'($urandom);
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                cyc_n(1);
                rst = 1'b0;
            end else begin
                cyc_n(1);
            end
        end
        bus.s_valid = 1'b0;
        cyc_n(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
